data_sync: RTL and testbench
============================

DATA_SYNC -- requirements
Module: data_sync

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 2, number of enable-synchronizer flip-flops; legal range 2..4.
REQ-002 SHALL have parameter BUS_WIDTH, default 8, width of the transferred data bus.
REQ-003 SHALL have port CLK  input  1  destination-domain clock; the block has one clock.
REQ-004 SHALL have port RST  input  1  reset; asynchronous, active-low; driven by the SYNC_RST output of the destination domain's reset synchronizer.
REQ-005 SHALL have port UNSYNC_BUS  input  BUS_WIDTH  source-domain data; stable whenever BUS_ENABLE is high.
REQ-006 SHALL have port BUS_ENABLE  input  1  source-domain level qualifier; asynchronous to CLK.
REQ-007 SHALL have port DATA_READY  input  1  consumer accepts SYNC_BUS when sampled high with DATA_VALID high.
REQ-008 SHALL have port CLR_OVERRUN  input  1  synchronous clear of OVERRUN and DROP_CNT.
REQ-009 SHALL have port SYNC_BUS  output  BUS_WIDTH  registered captured data.
REQ-010 SHALL have port ENABLE_PULSE  output  1  registered one-cycle strobe marking a new capture.
REQ-011 SHALL have port DATA_VALID  output  1  SYNC_BUS holds an unconsumed word.
REQ-012 SHALL have port OVERRUN  output  1  sticky flag: an unconsumed word was overwritten.
REQ-013 SHALL have port DROP_CNT  output  4  saturating count of overwritten words.

Function
REQ-014 SHALL pass BUS_ENABLE through a NUM_STAGES-deep flip-flop chain; UNSYNC_BUS SHALL never be synchronized bit-wise.
REQ-015 SHALL register the chain output once more and detect a rising edge (chain out = 1, delayed copy = 0).
REQ-016 SHALL, taking edge 0 as the first CLK edge that samples BUS_ENABLE = 1, load SYNC_BUS from UNSYNC_BUS and assert ENABLE_PULSE at edge NUM_STAGES.
REQ-017 SHALL deassert ENABLE_PULSE at edge NUM_STAGES+1, giving exactly one pulse per BUS_ENABLE rising edge regardless of high duration.
REQ-018 SHALL re-arm only after the chain output has been sampled low for at least one CLK edge.
REQ-019 SHALL hold SYNC_BUS unchanged in every cycle without a detected rising edge.
REQ-020 SHALL set DATA_VALID at the same edge as ENABLE_PULSE and keep it high until an edge with DATA_VALID = 1 and DATA_READY = 1.
REQ-021 SHALL ignore DATA_READY while DATA_VALID = 0.
REQ-022 SHALL, on a capture edge with DATA_VALID = 1 and DATA_READY = 0, overwrite SYNC_BUS with the new word, keep DATA_VALID = 1, set OVERRUN and increment DROP_CNT.
REQ-023 SHALL, on a capture edge with DATA_VALID = 1 and DATA_READY = 1, treat the old word as consumed: load the new word, keep DATA_VALID = 1, no OVERRUN, no DROP_CNT change.
REQ-024 SHALL saturate DROP_CNT at 15 with no wrap-around.
REQ-025 SHALL clear OVERRUN and DROP_CNT on an edge with CLR_OVERRUN = 1; if an overrun occurs at the same edge, set-wins: OVERRUN = 1, DROP_CNT = 1.
REQ-026 SHALL implement the handshake as a two-state machine: EMPTY (DATA_VALID = 0) -> FULL on capture; FULL -> EMPTY on accept without capture; FULL -> FULL on capture, with or without accept.

Reset
REQ-027 SHALL, while RST = 0, immediately force all synchronizer and edge-detect flops, SYNC_BUS, ENABLE_PULSE, DATA_VALID, OVERRUN and DROP_CNT to 0, independent of CLK.
REQ-028 SHALL discard any enable edge in flight when reset asserts mid-transfer; no ENABLE_PULSE SHALL result from it.
REQ-029 SHALL, after RST deasserts with BUS_ENABLE already high, produce one ENABLE_PULSE NUM_STAGES edges after the first post-reset edge.

Verification
REQ-030 Bench: NUM_STAGES = 2; UNSYNC_BUS = 0xA5; BUS_ENABLE high for 6 cycles -> SYNC_BUS = 0xA5 and ENABLE_PULSE = 1 at edge 2 only; DATA_VALID = 1 from edge 2.
REQ-031 Bench: 0x11 captured, DATA_READY held 0, then 0x22 captured -> SYNC_BUS = 0x22, OVERRUN = 1, DROP_CNT = 1, DATA_VALID = 1.
REQ-032 Bench: DATA_READY = 1 at the same edge as the second capture -> OVERRUN = 0, DROP_CNT = 0, DATA_VALID = 1, SYNC_BUS = new word.
REQ-033 Bench: 20 overrun captures without accept -> DROP_CNT = 15; CLR_OVERRUN pulse -> OVERRUN = 0, DROP_CNT = 0.
REQ-034 Bench: RST pulled low one cycle after BUS_ENABLE rises -> all outputs 0 asynchronously; BUS_ENABLE low before release -> no ENABLE_PULSE afterwards.
REQ-035 Bench: BUS_ENABLE toggled with random phase relative to CLK, NUM_STAGES = 3 -> ENABLE_PULSE count equals the number of BUS_ENABLE rising edges whose low phase spans at least one CLK edge; every pulse lasts exactly 1 cycle.

Source files
------------

// File: rtl/data_sync.sv
// Multi-bit clock-domain crossing: a level enable is synchronized, its rising edge
// captures the quasi-static bus, and a valid/ready holding register tracks overruns.
module data_sync #(
    parameter int NUM_STAGES = 2,
    parameter int BUS_WIDTH  = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
    input  logic                 BUS_ENABLE,
    input  logic                 DATA_READY,
    input  logic                 CLR_OVERRUN,
    output logic [BUS_WIDTH-1:0] SYNC_BUS,
    output logic                 ENABLE_PULSE,
    output logic                 DATA_VALID,
    output logic                 OVERRUN,
    output logic [3:0]           DROP_CNT
);

    typedef enum logic {
        StEmpty,
        StFull
    } state_e;

    logic [NUM_STAGES-1:0] sync_q, sync_d;
    logic                  dly_q, dly_d;
    logic [BUS_WIDTH-1:0]  bus_q, bus_d;
    logic                  pulse_q, pulse_d;
    logic                  ovr_q, ovr_d;
    logic [3:0]            cnt_q, cnt_d;
    state_e                state_q, state_d;

    logic rise;
    logic overrun_evt;

    // Only the enable crosses domains; the bus is sampled once it is known stable.
    assign rise        = sync_q[NUM_STAGES-1] & ~dly_q;
    assign overrun_evt = rise & (state_q == StFull) & ~DATA_READY;

    always_comb begin
        sync_d  = {sync_q[NUM_STAGES-2:0], BUS_ENABLE};
        dly_d   = sync_q[NUM_STAGES-1];
        pulse_d = rise;
        bus_d   = bus_q;
        state_d = state_q;
        ovr_d   = ovr_q;
        cnt_d   = cnt_q;

        if (rise) begin
            bus_d = UNSYNC_BUS;
        end

        unique case (state_q)
            StEmpty: if (rise) state_d = StFull;
            StFull:  if (!rise && DATA_READY) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase

        // A new overrun wins over a simultaneous clear and restarts the count at one.
        if (overrun_evt) begin
            ovr_d = 1'b1;
            if (CLR_OVERRUN) begin
                cnt_d = 4'd1;
            end else if (cnt_q != 4'd15) begin
                cnt_d = cnt_q + 4'd1;
            end
        end else if (CLR_OVERRUN) begin
            ovr_d = 1'b0;
            cnt_d = 4'd0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q  <= '0;
            dly_q   <= 1'b0;
            bus_q   <= '0;
            pulse_q <= 1'b0;
            ovr_q   <= 1'b0;
            cnt_q   <= 4'd0;
            state_q <= StEmpty;
        end else begin
            sync_q  <= sync_d;
            dly_q   <= dly_d;
            bus_q   <= bus_d;
            pulse_q <= pulse_d;
            ovr_q   <= ovr_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign SYNC_BUS     = bus_q;
    assign ENABLE_PULSE = pulse_q;
    assign DATA_VALID   = (state_q == StFull);
    assign OVERRUN      = ovr_q;
    assign DROP_CNT     = cnt_q;

endmodule

// File: tb/tb_data_sync.sv
// Directed bench for data_sync: capture timing, overrun/drop accounting, reset behaviour,
// and pulse counting with a randomly phased enable on a three-stage instance.
module tb_data_sync;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] unsync_bus;
    logic       bus_en;
    logic       data_ready;
    logic       clr_ovr;
    logic [7:0] sync_bus;
    logic       pulse;
    logic       valid;
    logic       ovr;
    logic [3:0] cnt;

    logic       en3;
    logic [7:0] sb3;
    logic       p3;
    logic       v3;
    logic       o3;
    logic [3:0] c3;

    int total = 0;
    int bad   = 0;

    int low_edges = 0;
    int p3_cnt    = 0;
    int run       = 0;
    int max_run   = 0;

    always #5 clk = ~clk;

    data_sync #(.NUM_STAGES(2), .BUS_WIDTH(8)) dut2 (
        .CLK          (clk),
        .RST          (rst_n),
        .UNSYNC_BUS   (unsync_bus),
        .BUS_ENABLE   (bus_en),
        .DATA_READY   (data_ready),
        .CLR_OVERRUN  (clr_ovr),
        .SYNC_BUS     (sync_bus),
        .ENABLE_PULSE (pulse),
        .DATA_VALID   (valid),
        .OVERRUN      (ovr),
        .DROP_CNT     (cnt)
    );

    data_sync #(.NUM_STAGES(3), .BUS_WIDTH(8)) dut3 (
        .CLK          (clk),
        .RST          (rst_n),
        .UNSYNC_BUS   (8'h3C),
        .BUS_ENABLE   (en3),
        .DATA_READY   (1'b1),
        .CLR_OVERRUN  (1'b0),
        .SYNC_BUS     (sb3),
        .ENABLE_PULSE (p3),
        .DATA_VALID   (v3),
        .OVERRUN      (o3),
        .DROP_CNT     (c3)
    );

    // Clock edges that see the three-stage enable low; a rise after any such edge is real.
    always @(posedge clk) begin
        if (!en3) low_edges <= low_edges + 1;
    end

    always @(negedge clk) begin
        if (p3) begin
            p3_cnt <= p3_cnt + 1;
            run    <= run + 1;
            if (run + 1 > max_run) max_run <= run + 1;
        end else begin
            run <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [7:0] word, input logic rdy, input logic clr);
        unsync_bus = word;
        bus_en     = 1'b1;
        tick();
        tick();
        data_ready = rdy;
        clr_ovr    = clr;
        tick();
        data_ready = 1'b0;
        clr_ovr    = 1'b0;
        bus_en     = 1'b0;
        tick();
        tick();
        tick();
    endtask

    // Random delay whose end never lands on a rising clock edge.
    task automatic wait_off(input int lo, input int hi);
        int    d;
        longint t;
        d = int'($urandom_range(hi, lo));
        t = longint'($time) + longint'(d);
        if ((t % 10) == 5) d++;
        #d;
    endtask

    initial begin
        int last_low;
        int exp_pulses;
        int pulses_seen;

        rst_n      = 1'b0;
        unsync_bus = 8'h00;
        bus_en     = 1'b0;
        data_ready = 1'b0;
        clr_ovr    = 1'b0;
        en3        = 1'b0;

        #2;
        check("rst_bus", 32'(sync_bus), 32'h0);
        check("rst_pulse", 32'(pulse), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_ovr", 32'(ovr), 32'h0);
        check("rst_cnt", 32'(cnt), 32'h0);
        #10;
        rst_n = 1'b1;
        tick();

        // Basic capture: enable high six cycles, single pulse at edge 2.
        unsync_bus = 8'hA5;
        bus_en     = 1'b1;
        tick();
        check("e0_pulse", 32'(pulse), 32'h0);
        check("e0_valid", 32'(valid), 32'h0);
        tick();
        check("e1_pulse", 32'(pulse), 32'h0);
        check("e1_bus", 32'(sync_bus), 32'h0);
        tick();
        check("e2_pulse", 32'(pulse), 32'h1);
        check("e2_bus", 32'(sync_bus), 32'hA5);
        check("e2_valid", 32'(valid), 32'h1);
        for (int i = 3; i < 6; i++) begin
            tick();
            check("hold_pulse", 32'(pulse), 32'h0);
            check("hold_valid", 32'(valid), 32'h1);
        end
        bus_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("drain_pulse", 32'(pulse), 32'h0);
        end
        check("hold_bus", 32'(sync_bus), 32'hA5);
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        check("accept_valid", 32'(valid), 32'h0);

        // Ready while empty has no effect.
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        check("idle_ready_valid", 32'(valid), 32'h0);

        // Overrun without accept.
        capture(8'h11, 1'b0, 1'b0);
        check("c11_bus", 32'(sync_bus), 32'h11);
        check("c11_ovr", 32'(ovr), 32'h0);
        capture(8'h22, 1'b0, 1'b0);
        check("ovr_bus", 32'(sync_bus), 32'h22);
        check("ovr_flag", 32'(ovr), 32'h1);
        check("ovr_cnt", 32'(cnt), 32'h1);
        check("ovr_valid", 32'(valid), 32'h1);

        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        check("clr1_ovr", 32'(ovr), 32'h0);
        check("clr1_cnt", 32'(cnt), 32'h0);
        check("clr1_valid", 32'(valid), 32'h1);

        // Accept coinciding with capture is not an overrun.
        capture(8'h33, 1'b1, 1'b0);
        check("acc_bus", 32'(sync_bus), 32'h33);
        check("acc_ovr", 32'(ovr), 32'h0);
        check("acc_cnt", 32'(cnt), 32'h0);
        check("acc_valid", 32'(valid), 32'h1);

        // Saturation of the drop counter.
        for (int i = 0; i < 20; i++) begin
            capture(8'(8'h40 + i), 1'b0, 1'b0);
            if (i == 13) check("cnt14", 32'(cnt), 32'd14);
        end
        check("sat_cnt", 32'(cnt), 32'd15);
        check("sat_ovr", 32'(ovr), 32'h1);
        check("sat_bus", 32'(sync_bus), 32'h53);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        check("clr2_ovr", 32'(ovr), 32'h0);
        check("clr2_cnt", 32'(cnt), 32'h0);

        // Clear and overrun at the same edge: set wins.
        capture(8'h77, 1'b0, 1'b1);
        check("setwin_ovr", 32'(ovr), 32'h1);
        check("setwin_cnt", 32'(cnt), 32'h1);
        check("setwin_bus", 32'(sync_bus), 32'h77);

        // Reset mid-transfer discards the edge in flight.
        unsync_bus = 8'h5A;
        bus_en     = 1'b1;
        tick();
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_bus", 32'(sync_bus), 32'h0);
        check("arst_valid", 32'(valid), 32'h0);
        check("arst_ovr", 32'(ovr), 32'h0);
        check("arst_cnt", 32'(cnt), 32'h0);
        check("arst_pulse", 32'(pulse), 32'h0);
        bus_en = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_rst_pulse", 32'(pulse), 32'h0);
            check("post_rst_valid", 32'(valid), 32'h0);
        end

        // Reset release with enable already high.
        rst_n = 1'b0;
        #2;
        unsync_bus = 8'hC3;
        bus_en     = 1'b1;
        #2;
        rst_n = 1'b1;
        tick();
        check("rel_e0_pulse", 32'(pulse), 32'h0);
        tick();
        check("rel_e1_pulse", 32'(pulse), 32'h0);
        tick();
        check("rel_e2_pulse", 32'(pulse), 32'h1);
        check("rel_e2_bus", 32'(sync_bus), 32'hC3);
        tick();
        check("rel_e3_pulse", 32'(pulse), 32'h0);
        bus_en = 1'b0;
        tick();
        tick();
        tick();

        // Randomly phased enable on the three-stage instance.
        last_low   = low_edges;
        exp_pulses = 0;
        pulses_seen = p3_cnt;
        for (int k = 0; k < 40; k++) begin
            wait_off(3, 30);
            if (low_edges != last_low) exp_pulses++;
            en3 = 1'b1;
            wait_off(12, 30);
            en3      = 1'b0;
            last_low = low_edges;
        end
        repeat (10) tick();
        check("rand_pulses", 32'(p3_cnt - pulses_seen), 32'(exp_pulses));
        check("rand_width", 32'(max_run), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
